// File: rtl/cache_pkg.sv
// Shared constants and FSM encoding for the two-way write-through read cache.
package cache_pkg;

  localparam int          SET_BITS  = 6;
  localparam int          TAG_BITS  = 11;
  localparam logic [31:0] BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_t;

endpackage

// File: rtl/cache_mem.sv
// Tag/valid/data/lru storage for a two-way set-associative cache.
// Lookups are combinational; fills, write-hit updates and lru touches happen on the clock edge.
module cache_mem #(
  parameter int SET_BITS = cache_pkg::SET_BITS,
  parameter int TAG_BITS = cache_pkg::TAG_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SET_BITS-1:0] idx,
  input  logic [TAG_BITS-1:0] tag,
  input  logic [31:0]         wr_data,
  input  logic                fill_en,
  input  logic                upd_en,
  input  logic                touch_en,
  output logic                hit,
  output logic                hit_way,
  output logic [31:0]         hit_data,
  output logic                victim
);

  localparam int SETS = 1 << SET_BITS;

  logic                valid_q [2][SETS];
  logic [TAG_BITS-1:0] tag_q   [2][SETS];
  logic [31:0]         data_q  [2][SETS];
  logic                lru_q   [SETS];

  logic hit0, hit1;

  assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1     = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  assign hit_data = hit1 ? data_q[1][idx] : data_q[0][idx];
  assign victim   = !valid_q[0][idx] ? 1'b0 :
                    !valid_q[1][idx] ? 1'b1 : lru_q[idx];

  // lru always points at the way that was not just used
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[0][s] <= 1'b0;
        valid_q[1][s] <= 1'b0;
        lru_q[s]      <= 1'b0;
      end
    end else if (fill_en) begin
      valid_q[victim][idx] <= 1'b1;
      lru_q[idx]           <= ~victim;
    end else if (upd_en || touch_en) begin
      lru_q[idx]           <= ~hit_way;
    end
  end

  // NOTE: tag and data arrays carry no reset; clearing valid is enough to make
  // their contents irrelevant, and leaving them unreset lets them map onto RAM.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[victim][idx]  <= tag;
      data_q[victim][idx] <= wr_data;
    end else if (upd_en) begin
      data_q[hit_way][idx] <= wr_data;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Two-way write-through, no-write-allocate read cache between the MEM stage and the
// SRAM controller. Hits complete in the same cycle; misses and writes go to SRAM.
module cache_controller
  import cache_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = cache_pkg::BASE_ADDR,
  parameter int          SET_BITS  = cache_pkg::SET_BITS,
  parameter int          TAG_BITS  = cache_pkg::TAG_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [31:0] addr,
  input  logic [31:0] st_val,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        sram_read_en,
  output logic        sram_write_en,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_st_val,
  input  logic [31:0] sram_read_data,
  input  logic        sram_ready
);

  state_t state, next_state;

  logic [31:0]         offset;
  logic [SET_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;
  logic                unused_offset_bits;

  logic        hit, hit_way, victim;
  logic [31:0] hit_data, wr_data;
  logic        fill_en, upd_en, touch_en;

  assign offset             = addr - BASE_ADDR;
  assign idx                = offset[2 +: SET_BITS];
  assign tag                = offset[2 + SET_BITS +: TAG_BITS];
  assign unused_offset_bits = ^{offset[1:0], offset[31:2 + SET_BITS + TAG_BITS]};

  assign sram_addr    = addr;
  assign sram_st_val  = st_val;
  assign wr_data      = (state == WR_THRU) ? st_val : sram_read_data;

  cache_mem #(
    .SET_BITS (SET_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx),
    .tag      (tag),
    .wr_data  (wr_data),
    .fill_en  (fill_en),
    .upd_en   (upd_en),
    .touch_en (touch_en),
    .hit      (hit),
    .hit_way  (hit_way),
    .hit_data (hit_data),
    .victim   (victim)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    next_state    = state;
    ready         = 1'b0;
    read_data     = '0;
    sram_read_en  = 1'b0;
    sram_write_en = 1'b0;
    fill_en       = 1'b0;
    upd_en        = 1'b0;
    touch_en      = 1'b0;
    unique case (state)
      IDLE: begin
        if (write_en) begin
          next_state = WR_THRU;
        end else if (read_en) begin
          if (hit) begin
            ready     = 1'b1;
            read_data = hit_data;
            touch_en  = 1'b1;
          end else begin
            next_state = RD_MISS;
          end
        end else begin
          ready = 1'b1;
        end
      end
      RD_MISS: begin
        sram_read_en = 1'b1;
        if (sram_ready) begin
          ready      = 1'b1;
          read_data  = sram_read_data;
          fill_en    = 1'b1;
          next_state = IDLE;
        end
      end
      WR_THRU: begin
        sram_write_en = 1'b1;
        if (sram_ready) begin
          ready      = 1'b1;
          upd_en     = hit;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Two-way set-associative, write-through, no-write-allocate read cache between the MEM stage and the SRAM controller. Read hits return data in the same cycle. Read misses and all writes are sequenced onto the SRAM controller's enable/ready handshake. The pipeline stalls on `ready=0` exactly as it does with the bare SRAM controller, so the block drops in between them unchanged.

## Interface
Parameters:
- `BASE_ADDR`, 1024: data-memory base; subtracted from `addr` before indexing.
- `SET_BITS`, 6: 64 sets; index = `(addr-BASE_ADDR)[7:2]`.
- `TAG_BITS`, 11: tag = `(addr-BASE_ADDR)[18:8]`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous active-high reset.
- `read_en` in 1: MEM-stage load request, held until `ready`.
- `write_en` in 1: MEM-stage store request, held until `ready`.
- `addr` in 32: byte address, word-aligned, ≥ `BASE_ADDR`.
- `st_val` in 32: store data.
- `read_data` out 32: load result, valid when `ready & read_en`.
- `ready` out 1: request complete / no request pending.
- `sram_read_en` out 1: to SRAM controller `read_en`.
- `sram_write_en` out 1: to SRAM controller `write_en`.
- `sram_addr` out 32: to SRAM controller `addr`; equals `addr`.
- `sram_st_val` out 32: to SRAM controller `st_val`; equals `st_val`.
- `sram_read_data` in 32: from SRAM controller.
- `sram_ready` in 1: from SRAM controller.

## Operation
- Per set: `valid[2]`, `tag[2]`, `data[2]`, and 1 `lru` bit naming the least-recently-used way.
- Hit = `valid[w] && tag[w]==addr tag`. Both ways hitting is impossible by construction.
- States: `IDLE`, `RD_MISS`, `WR_THRU`.
- In `IDLE`:
  - `write_en` goes to `WR_THRU`. Write takes precedence if both enables are high; that case is illegal stimulus.
  - `read_en` with a hit goes nowhere: `ready=1`, `read_data` = hit way's data, and `lru` is set to the other way on that clock.
  - `read_en` with a miss goes to `RD_MISS`.
- In `RD_MISS`:
  - `sram_read_en=1` until `sram_ready`.
  - In the `sram_ready` cycle: `ready=1` and `read_data=sram_read_data`.
  - On that edge, fill the victim and return to `IDLE`. Victim = way0 if invalid, else way1 if invalid, else `lru`. Fill sets valid, tag and data, and sets `lru` to the other way.
- In `WR_THRU`:
  - `sram_write_en=1` until `sram_ready`. In the `sram_ready` cycle `ready=1`; go to `IDLE` on that edge.
  - On the same edge, a hit way has its data replaced with `st_val` and `lru` updated.
  - A miss does not allocate.
- `ready` rules:
  - `ready=1` in `IDLE` when there is no request.
  - `ready=0` in `IDLE` on a read miss or any write.
  - In the other states, `ready = sram_ready`.
- `read_data` is 0 whenever it is not being driven per the rules above.
- The SRAM enables are Moore outputs of the state: both are 0 in `IDLE`.

## Timing
- Reset values: state `IDLE`, all `valid=0`, all `lru=0`, `sram_read_en=0`, `sram_write_en=0`, `ready=1` (no request), `read_data=0`.
- Latency:
  - Read hit: 0 extra cycles (`ready` in the same cycle).
  - Read miss: 1 `IDLE` cycle + SRAM latency. `ready` is asserted in the `sram_ready` cycle.
  - Write: same as read miss.
- The mandatory `IDLE` cycle after every SRAM transaction guarantees the SRAM enables drop for at least one cycle between transactions.
- Back-to-back hits: one per cycle.
- Reset mid-transaction: the next edge forces `IDLE`, deasserts both SRAM enables and invalidates all lines. The SRAM controller is reset by the same `rst`.
- Request dropped mid-miss: illegal. The block is not required to abort, and completes the SRAM access.
- `sram_ready` high while in `IDLE`: ignored.

## Structure
- Package `cache_pkg`: `SET_BITS`, `TAG_BITS`, `BASE_ADDR`, state enum encoding (`IDLE=0`, `RD_MISS=1`, `WR_THRU=2`).
- Sub-module `cache_mem`: tag/valid/data/lru arrays.
  - Combinational read: hit, hit way, data, victim.
  - Synchronous write ports for fill, write-hit update, lru update and reset-clear.
- The top level holds only the FSM and muxing.

## Test plan
- Cold read at `addr=1024`, SRAM holds `0xDEADBEEF`:
  - `ready=0`, then `ready=1` with `read_data=0xDEADBEEF` in the `sram_ready` cycle.
  - Immediate re-read hits with `ready=1` and no `sram_read_en`.
- Read 1024, 1280, 1536 (same set 0, three tags):
  - Third access evicts the 1024 line (LRU).
  - Re-read of 1280 hits; re-read of 1024 misses.
- Write `0x12345678` to 1024 after it is cached:
  - `sram_write_en` is held until `sram_ready`.
  - Following read hits and returns `0x12345678`.
- Write to uncached 2048, then read 2048:
  - The write does not allocate.
  - The read misses and returns the SRAM value.
- Assert `rst` in the 3rd cycle of `RD_MISS`:
  - Next cycle: both SRAM enables are 0 and `ready=1`.
  - Previously cached 1024 now misses.
- Ten consecutive hits alternating two cached addresses: `ready=1` every cycle and zero SRAM enables.
